// File: rtl/iic_pkg.sv
// Shared encodings for the IIC EEPROM transaction arbiter: engine call codes,
// arbiter state type and the EEPROM device address.
package iic_pkg;

  localparam logic [1:0] CALL_NONE = 2'b00;
  localparam logic [1:0] CALL_WR   = 2'b10;
  localparam logic [1:0] CALL_RD   = 2'b01;

  localparam logic [6:0] EEPROM_DEV_ADDR = 7'b1010000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALL   = 3'd1,
    ST_RESP   = 3'd2,
    ST_WRWAIT = 3'd3,
    ST_ABORT  = 3'd4
  } state_e;

  function automatic logic [1:0] call_enc(input logic we);
    return we ? CALL_WR : CALL_RD;
  endfunction

endpackage

// File: rtl/iic_rr_arb2.sv
// Two-way round-robin grant. last_q resets to 1 so requester 0 wins the
// first tie; a lone requester always wins.
module iic_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  logic last_q;

  always_comb begin
    grant_valid_o = |valid_i;
    if (valid_i[0] && valid_i[1]) begin
      grant_o = ~last_q;
    end else if (valid_i[1]) begin
      grant_o = 1'b1;
    end else begin
      grant_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= grant_o;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/iic_eeprom_arbiter.sv
// Two-client scheduler in front of the single-byte IIC EEPROM engine: grants,
// holds the engine call until done, enforces write recovery and aborts hung calls.
module iic_eeprom_arbiter
  import iic_pkg::*;
#(
  parameter int TWR_CYCLES     = 250000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_err,
  output logic [1:0] iic_call,
  output logic [7:0] iic_addr,
  output logic [7:0] iic_wdata,
  input  logic [7:0] iic_rdata,
  input  logic       iic_done,
  output logic       iic_abort_n,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TWR_LAST   = CNT_W'(TWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ABORT_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d, rid_q, rid_d, err_q, err_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]       call_q, call_d;
  logic             abort_n_q, abort_n_d, busy_q, busy_d;
  logic             rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
  logic [7:0]       rsp0_rdata_q, rsp1_rdata_q;
  logic             grant, grant_valid, accept, rsp_load;
  logic [7:0]       rsp_rdata;

  iic_rr_arb2 u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       ({req1_valid, req0_valid}),
    .update_i      (accept),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign accept     = (state_q == ST_IDLE) && grant_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // Next-state logic; the one counter times both the call timeout and write recovery.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    rid_d     = rid_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_load  = 1'b0;
    rsp_rdata = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = grant ? req1_we    : req0_we;
          addr_d  = grant ? req1_addr  : req0_addr;
          wdata_d = grant ? req1_wdata : req0_wdata;
          rid_d   = grant;
          cnt_d   = CNT_ZERO;
          state_d = ST_CALL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALL: begin
        cnt_d = cnt_q + CNT_ONE;
        if (iic_done) begin
          rsp_load  = 1'b1;
          rsp_rdata = we_q ? 8'h00 : iic_rdata;
          err_d     = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_ABORT;
        end else begin
          state_d = ST_CALL;
        end
      end
      ST_ABORT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == ABORT_LAST) begin
          rsp_load = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_RESP: begin
        if (we_q && !err_q) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_WRWAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRWAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == TWR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRWAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    call_d    = (state_d == ST_CALL) ? call_enc(we_d) : CALL_NONE;
    abort_n_d = (state_d != ST_ABORT);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, latched request and registered engine/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      we_q         <= 1'b0;
      rid_q        <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      call_q       <= CALL_NONE;
      abort_n_q    <= 1'b1;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= 8'h00;
      rsp1_rdata_q <= 8'h00;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      rid_q        <= rid_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      call_q       <= call_d;
      abort_n_q    <= abort_n_d;
      busy_q       <= busy_d;
      rsp0_valid_q <= rsp_load && !rid_q;
      rsp1_valid_q <= rsp_load && rid_q;
      if (rsp_load && !rid_q) begin
        rsp0_rdata_q <= rsp_rdata;
        rsp0_err_q   <= err_d;
      end else begin
        rsp0_rdata_q <= rsp0_rdata_q;
        rsp0_err_q   <= rsp0_err_q;
      end
      if (rsp_load && rid_q) begin
        rsp1_rdata_q <= rsp_rdata;
        rsp1_err_q   <= err_d;
      end else begin
        rsp1_rdata_q <= rsp1_rdata_q;
        rsp1_err_q   <= rsp1_err_q;
      end
    end
  end

  assign iic_call    = call_q;
  assign iic_addr    = addr_q;
  assign iic_wdata   = wdata_q;
  assign iic_abort_n = abort_n_q;
  assign busy        = busy_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_rdata  = rsp0_rdata_q;
  assign rsp0_err    = rsp0_err_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_rdata  = rsp1_rdata_q;
  assign rsp1_err    = rsp1_err_q;

endmodule

// File: tb/tb_iic_eeprom_arbiter.sv
// Scoreboard bench for iic_eeprom_arbiter with a behavioural EEPROM engine
// that answers a configurable number of cycles into each call.
module tb_iic_eeprom_arbiter;
  import iic_pkg::*;

  typedef struct {
    int         id;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic       clk, rst_n;
  logic       req0_valid, req0_we, req0_ready, req1_valid, req1_we, req1_ready;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [1:0] iic_call;
  logic [7:0] iic_addr, iic_wdata, iic_rdata;
  logic       iic_done, iic_abort_n, busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = -100;
  int   eng_delay = 10;
  int   eng_n;
  exp_t exp_q[$];
  logic [7:0] mem [256];

  iic_eeprom_arbiter #(.TWR_CYCLES(20), .TIMEOUT_CYCLES(50), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .iic_call(iic_call), .iic_addr(iic_addr), .iic_wdata(iic_wdata),
    .iic_rdata(iic_rdata), .iic_done(iic_done), .iic_abort_n(iic_abort_n),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: done pulse in the eng_delay-th cycle of a call (0 = never answer).
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h3C] = 8'hA5;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    iic_done  = 1'b0;
    iic_rdata = 8'h00;
    eng_n     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (iic_done) begin
        iic_done  = 1'b0;
        iic_rdata = 8'h00;
        eng_n     = 0;
      end else if (iic_call != 2'b00) begin
        eng_n++;
        if (eng_delay != 0 && eng_n == eng_delay) begin
          iic_done = 1'b1;
          if (iic_call == 2'b01) iic_rdata = mem[iic_addr];
          else mem[iic_addr] = iic_wdata;
        end
      end else begin
        eng_n = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin
    exp_t e;
    int   id;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (iic_done) done_cyc = cyc;
        if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
        if (rsp0_valid || rsp1_valid) begin
          id = rsp1_valid ? 1 : 0;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(id), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(id), 32'(e.id));
            chk("rsp_rdata", id ? rsp1_rdata : rsp0_rdata, e.rdata);
            chk("rsp_err", id ? rsp1_err : rsp0_err, e.err);
            if (!e.err) chk("rsp_latency", 32'(cyc - done_cyc), 32'd1);
          end
        end
      end
    end
  end

  task automatic send(input int id, input logic we, input logic [7:0] addr,
                      input logic [7:0] wd, input logic [7:0] exp_rd,
                      input logic push, output int acc);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    if (id == 0) begin
      req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
    end
    acc = -1;
    n   = 0;
    while (n < 300) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        acc = cyc;
        break;
      end
      n++;
    end
    chk("accept", 32'(acc >= 0), 32'd1);
    if (push && acc >= 0) begin
      e.id = id; e.rdata = exp_rd; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_done(output int d);
    int n;
    d = -1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (iic_done) begin
        d = cyc;
        break;
      end
      n++;
    end
    chk("done_seen", 32'(d >= 0), 32'd1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, d, n, m, who;
    exp_t e;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    $display("EEPROM device address 0x%h", EEPROM_DEV_ADDR);
    repeat (3) @(negedge clk);
    chk("rst_call", iic_call, 2'b00);
    chk("rst_abort_n", iic_abort_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", iic_addr, 8'h00);
    chk("rst_wdata", iic_wdata, 8'h00);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_rsp", {rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, rsp1_rdata, rsp0_rdata}, 20'h0);
    rst_n = 1'b1;

    // Read from requester 0.
    send(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1, acc);
    @(negedge clk);
    chk("rd_call", iic_call, 2'b01);
    chk("rd_addr", iic_addr, 8'h3C);
    wait_done(d);
    @(negedge clk);
    chk("rd_busy_resp", busy, 1'b1);
    @(negedge clk);
    chk("rd_busy_idle", busy, 1'b0);
    wait_empty();

    // Write from requester 1, then measure the recovery gap before the next grant.
    send(1, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b1, acc);
    @(negedge clk);
    chk("wr_call", iic_call, 2'b10);
    chk("wr_addr", iic_addr, 8'h10);
    chk("wr_wdata", iic_wdata, 8'h5A);
    wait_done(d);
    send(1, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b1, acc);
    chk("wr_recovery_gap", 32'(acc - d), 32'd22);
    wait_empty();

    // Both requesters continuously valid: grants must alternate 0,1,0,1.
    @(posedge clk);
    #1;
    req0_we = 1'b0; req0_addr = 8'h20; req0_valid = 1'b1;
    req1_we = 1'b0; req1_addr = 8'h21; req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("rr_ready_onehot", {req1_ready, req0_ready} == 2'b11 ? 32'd1 : 32'd0, 32'd0);
      who = req1_ready ? 1 : 0;
      chk("rr_grant_order", 32'(who), 32'(g % 2));
      e.id = who; e.rdata = who ? 8'h22 : 8'h11; e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (g == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    wait_empty();

    // Engine never answers: timeout, 2-cycle abort, error response.
    eng_delay = 0;
    send(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, acc);
    e.id = 0; e.rdata = 8'h00; e.err = 1'b1;
    exp_q.push_back(e);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (iic_call == 2'b00) break;
      n++;
    end
    chk("to_call_cycles", 32'(n), 32'd50);
    m = 0;
    while (!iic_abort_n && m < 10) begin
      m++;
      @(negedge clk);
    end
    chk("to_abort_cycles", 32'(m), 32'd2);
    wait_empty();

    // Done coincides with the last timeout cycle: done wins.
    eng_delay = 50;
    send(1, 1'b0, 8'h21, 8'h00, 8'h22, 1'b1, acc);
    n = 0;
    m = 0;
    while (exp_q.size() != 0 && m < 300) begin
      @(negedge clk);
      if (!iic_abort_n) n++;
      m++;
    end
    chk("race_abort_low_cycles", 32'(n), 32'd0);
    wait_empty();

    // Reset in the middle of a call: call drops at once, no response.
    eng_delay = 10;
    send(0, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0, acc);
    repeat (5) @(negedge clk);
    chk("mid_call_active", iic_call, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_call", iic_call, 2'b00);
    chk("rst_async_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1, acc);
    wait_empty();
    repeat (30) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
